// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: single-cycle pipelined hits, whole-line refill on miss,
// global flush (deferred until the refill completes when one is in flight).
module icache_dm #(
   parameter int LINE_WORDS = 4,
   parameter int NUM_LINES  = 64,
   parameter bit BSWAP      = 1'b1
) (
   input  logic        CLK,
   input  logic        icache_rst,
   input  logic        icache_req,
   input  logic [31:0] icache_addr,
   output logic        icache_ready,
   output logic        icache_vld,
   output logic [31:0] icache_data,
   input  logic        icache_flush,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic        mem_rvld,
   input  logic [31:0] mem_rdata
);

   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = 30 - OFF_W - IDX_W;
   localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

   // Handshakes: a fetch is accepted on a rising CLK edge where icache_req && icache_ready;
   // icache_vld pulses once per accepted fetch. mem_req is held with a stable mem_addr until
   // the edge where mem_ack is seen; mem_rvld beats are taken on any edge in REFILL_DATA.
   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_REFILL_REQ,
      S_REFILL_DATA,
      S_RESP
   } state_t;

   state_t state;

   logic [TAG_W-1:0]  tag_mem  [NUM_LINES];
   logic [31:0]       data_mem [NUM_LINES*LINE_WORDS];
   logic [NUM_LINES-1:0] valid;

   logic [TAG_W-1:0]  tag_r;
   logic [IDX_W-1:0]  idx_r;
   logic [OFF_W-1:0]  off_r;
   logic [TAG_W-1:0]  tag_q;
   logic [31:0]       data_q;
   logic [31:0]       resp_q;
   logic [OFF_W-1:0]  beat_cnt;
   logic              flush_pend;

   logic [TAG_W-1:0]  a_tag;
   logic [IDX_W-1:0]  a_idx;
   logic [OFF_W-1:0]  a_off;
   logic              hit;
   logic              accept;
   logic              beat_wr;
   logic              last_beat;
   logic [31:0]       fill_word;
   logic              addr_unused;

   assign a_off = icache_addr[2 +: OFF_W];
   assign a_idx = icache_addr[2+OFF_W +: IDX_W];
   assign a_tag = icache_addr[2+OFF_W+IDX_W +: TAG_W];
   assign addr_unused = &{1'b0, icache_addr[1:0]};

   assign hit       = (state == S_LOOKUP) && valid[idx_r] && (tag_q == tag_r);
   assign icache_ready = ((state == S_IDLE) || hit) && !icache_flush && !flush_pend;
   assign accept    = icache_req && icache_ready;
   assign icache_vld  = hit || (state == S_RESP);
   assign icache_data = (state == S_LOOKUP) ? data_q : resp_q;

   assign beat_wr   = (state == S_REFILL_DATA) && mem_rvld;
   assign last_beat = beat_wr && (beat_cnt == LAST_BEAT);
   assign fill_word = BSWAP ? {mem_rdata[7:0], mem_rdata[15:8], mem_rdata[23:16], mem_rdata[31:24]}
                            : mem_rdata;

   // Tag/data storage: synchronous read on acceptance, writes only during refill, so the two never collide.
   always_ff @(posedge CLK) begin
      if (beat_wr) begin
         data_mem[{idx_r, beat_cnt}] <= fill_word;
      end
      if (last_beat) begin
         tag_mem[idx_r] <= tag_r;
      end
      if (accept) begin
         data_q <= data_mem[{a_idx, a_off}];
         tag_q  <= tag_mem[a_idx];
      end
   end

   always_ff @(posedge CLK or posedge icache_rst) begin
      if (icache_rst) begin
         state      <= S_IDLE;
         valid      <= '0;
         tag_r      <= '0;
         idx_r      <= '0;
         off_r      <= '0;
         beat_cnt   <= '0;
         flush_pend <= 1'b0;
         resp_q     <= '0;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
      end else begin
         if (accept) begin
            tag_r <= a_tag;
            idx_r <= a_idx;
            off_r <= a_off;
         end
         case (state)
            S_IDLE: begin
               if (icache_flush) valid <= '0;
               if (accept) state <= S_LOOKUP;
            end
            S_LOOKUP: begin
               // The compare above used the pre-flush valid bits; clearing lands at this edge.
               if (icache_flush) valid <= '0;
               if (hit) begin
                  state <= accept ? S_LOOKUP : S_IDLE;
               end else begin
                  state    <= S_REFILL_REQ;
                  mem_req  <= 1'b1;
                  mem_addr <= {tag_r, idx_r, {(OFF_W+2){1'b0}}};
               end
            end
            S_REFILL_REQ: begin
               if (icache_flush) flush_pend <= 1'b1;
               if (mem_ack) begin
                  mem_req  <= 1'b0;
                  beat_cnt <= '0;
                  state    <= S_REFILL_DATA;
               end
            end
            S_REFILL_DATA: begin
               if (icache_flush) flush_pend <= 1'b1;
               if (beat_wr) begin
                  beat_cnt <= beat_cnt + 1'b1;
                  if (beat_cnt == off_r) resp_q <= fill_word;
                  if (last_beat) begin
                     valid[idx_r] <= 1'b1;
                     state        <= S_RESP;
                  end
               end
            end
            S_RESP: begin
               // A deferred flush also wipes the line just filled.
               if (flush_pend || icache_flush) valid <= '0;
               flush_pend <= 1'b0;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: stimulus pushes expected words into a scoreboard queue,
// a negedge monitor pops and compares them whenever icache_vld is seen.
module tb_icache_dm;

   logic        CLK = 1'b0;
   logic        icache_rst;
   logic        icache_req;
   logic [31:0] icache_addr;
   logic        icache_ready;
   logic        icache_vld;
   logic [31:0] icache_data;
   logic        icache_flush;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic        mem_rvld;
   logic [31:0] mem_rdata;

   icache_dm dut (
      .CLK          (CLK),
      .icache_rst   (icache_rst),
      .icache_req   (icache_req),
      .icache_addr  (icache_addr),
      .icache_ready (icache_ready),
      .icache_vld   (icache_vld),
      .icache_data  (icache_data),
      .icache_flush (icache_flush),
      .mem_req      (mem_req),
      .mem_addr     (mem_addr),
      .mem_ack      (mem_ack),
      .mem_rvld     (mem_rvld),
      .mem_rdata    (mem_rdata)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int last_vld_cyc = -1;
   int lb_cyc = 0;
   int req_cycles = 0;
   logic [31:0] exp_q[$];
   int          exp_cyc_q[$];

   logic [31:0] beats_a [4] = '{32'h11223344, 32'h55667788, 32'hAABBCCDD, 32'h01020304};
   logic [31:0] beats_b [4] = '{32'hCAFEBABE, 32'hDEADBEEF, 32'h0BADF00D, 32'h12345678};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h @cyc %0d", name, act, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge CLK);
      cyc++;
   end

   // Monitor: pop one expectation per icache_vld cycle.
   initial begin
      logic [31:0] e;
      int          c;
      forever begin
         @(negedge CLK);
         if (mem_req) req_cycles++;
         if (!icache_rst && icache_vld) begin
            last_vld_cyc = cyc;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_vld actual=%h required=no_response @cyc %0d", icache_data, cyc);
            end else begin
               e = exp_q.pop_front();
               c = exp_cyc_q.pop_front();
               check("resp_data", icache_data, e);
               if (c != 0) check("resp_cycle", 32'(cyc), 32'(c));
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge CLK);
   endtask

   // Entered at a negedge; leaves req asserted so callers can chain back-to-back fetches.
   task automatic issue(input logic [31:0] a, input logic [31:0] exp, input bit chk_cyc);
      bit acc = 1'b0;
      int n = 0;
      icache_req  = 1'b1;
      icache_addr = a;
      while (!acc && n < 100) begin
         #1;
         acc = icache_ready;
         if (acc) begin
            exp_q.push_back(exp);
            exp_cyc_q.push_back(chk_cyc ? cyc + 1 : 0);
         end
         @(posedge CLK);
         @(negedge CLK);
         n++;
      end
      if (!acc) begin
         n_cmp++;
         n_err++;
         $display("FAIL accept_timeout actual=not_accepted required=accepted addr=%h", a);
      end
   endtask

   task automatic mem_serve(input logic [31:0] exp_addr, input int which, input int ack_dly,
                            input int gap, input int flush_beat, input int rst_after);
      int n = 0;
      bit stable = 1'b1;
      while (!mem_req && n < 60) begin
         @(negedge CLK);
         n++;
      end
      if (!mem_req) begin
         n_cmp++;
         n_err++;
         $display("FAIL mem_req_timeout actual=0 required=1 addr=%h", exp_addr);
         return;
      end
      check("mem_addr", mem_addr, exp_addr);
      for (int i = 0; i < ack_dly; i++) begin
         @(negedge CLK);
         if (!(mem_req && mem_addr == exp_addr)) stable = 1'b0;
      end
      if (ack_dly > 0) check("mem_req_stable", 32'(stable), 32'd1);
      mem_ack = 1'b1;
      @(negedge CLK);
      mem_ack = 1'b0;
      for (int b = 0; b < 4; b++) begin
         if (b > 0) repeat (gap) @(negedge CLK);
         mem_rvld  = 1'b1;
         mem_rdata = which != 0 ? beats_b[b] : beats_a[b];
         if (b == flush_beat) icache_flush = 1'b1;
         lb_cyc = cyc;
         @(negedge CLK);
         mem_rvld     = 1'b0;
         mem_rdata    = '0;
         icache_flush = 1'b0;
         if (b == rst_after) begin
            icache_rst = 1'b1;
            #2;
            check("rst_mem_req", 32'(mem_req), 32'd0);
            check("rst_ready", 32'(icache_ready), 32'd1);
            check("rst_vld", 32'(icache_vld), 32'd0);
            @(negedge CLK);
            icache_rst = 1'b0;
            return;
         end
      end
   endtask

   task automatic miss(input logic [31:0] a, input logic [31:0] exp, input logic [31:0] line,
                       input int which, input int ack_dly, input int gap, input int flush_beat);
      fork
         begin
            issue(a, exp, 1'b0);
            icache_req = 1'b0;
         end
         mem_serve(line, which, ack_dly, gap, flush_beat, -1);
      join
      idle(2);
      check("miss_latency", 32'(last_vld_cyc), 32'(lb_cyc + 1));
   endtask

   initial begin
      int rc0;
      icache_rst   = 1'b1;
      icache_req   = 1'b0;
      icache_addr  = '0;
      icache_flush = 1'b0;
      mem_ack      = 1'b0;
      mem_rvld     = 1'b0;
      mem_rdata    = '0;
      idle(3);
      icache_rst = 1'b0;
      #1;
      check("reset_ready", 32'(icache_ready), 32'd1);
      check("reset_vld", 32'(icache_vld), 32'd0);
      check("reset_mem_req", 32'(mem_req), 32'd0);
      check("reset_mem_addr", mem_addr, 32'd0);
      check("reset_data", icache_data, 32'd0);
      @(negedge CLK);

      // Cold miss, then back-to-back hits on the filled line.
      miss(32'h108, 32'hDDCCBBAA, 32'h100, 0, 0, 0, -1);
      rc0 = req_cycles;
      issue(32'h100, 32'h44332211, 1'b1);
      issue(32'h104, 32'h88776655, 1'b1);
      issue(32'h10C, 32'h04030201, 1'b1);
      icache_req = 1'b0;
      idle(3);
      check("hits_no_mem_req", 32'(req_cycles), 32'(rc0));

      // Conflict eviction: 0x500 shares index 0x10 with 0x100.
      miss(32'h500, 32'hBEBAFECA, 32'h500, 1, 0, 0, -1);
      miss(32'h104, 32'h88776655, 32'h100, 0, 0, 0, -1);

      // Flush in IDLE.
      issue(32'h10C, 32'h04030201, 1'b1);
      icache_req = 1'b0;
      idle(2);
      icache_flush = 1'b1;
      #1;
      check("ready_during_flush", 32'(icache_ready), 32'd0);
      @(negedge CLK);
      icache_flush = 1'b0;
      miss(32'h100, 32'h44332211, 32'h100, 0, 0, 0, -1);

      // Flush during refill data: response still delivered, line gone afterwards.
      miss(32'h204, 32'hEFBEADDE, 32'h200, 1, 0, 1, 1);
      miss(32'h200, 32'hBEBAFECA, 32'h200, 1, 0, 0, -1);

      // Slow ack and gapped beats.
      miss(32'h30C, 32'h78563412, 32'h300, 1, 5, 2, -1);

      // Reset after beat 2 of a refill, then the same address refills from scratch.
      fork
         begin
            issue(32'h408, 32'hDDCCBBAA, 1'b0);
            icache_req = 1'b0;
         end
         mem_serve(32'h400, 0, 0, 0, -1, 2);
      join
      exp_q.delete();
      exp_cyc_q.delete();
      idle(2);
      miss(32'h408, 32'hDDCCBBAA, 32'h400, 0, 0, 0, -1);

      idle(5);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1, "watchdog expired");
   end

endmodule
